// File: rtl/vote_pkg.sv
// Purpose: shared FSM encodings, width helpers and the one-hot test for the vote tally.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vote_pkg;

    // FSM encodings kept as plain constants so older tools and scripts can decode them.
    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_ARMED  = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_CLOSED = 3'd4;

    typedef logic [2:0] state_t;

    // res_idx must reach N_CAND, which selects the spoiled counter.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    // leader only ever names a candidate, 0..N_CAND-1.
    function automatic int lead_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Keypad is at most 16 wide; callers zero-extend into this argument.
    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/vote_edge_det.sv
// Purpose: rising-edge pulse for one operator push-button.
// Latency: combinational pulse in the cycle the input is first seen high.
// Backpressure: none.
// Ports: i_clk clock, i_rst sync active-high reset, i_d level input, o_rise edge pulse.
module vote_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/vote_tally.sv
// Purpose: ballot tally - per-candidate, spoiled and grand-total counters with a polling FSM.
// Latency: key sampled in cycle t updates counters, out and pulses in cycle t+1.
// Backpressure: none; button inputs are edge detected, keys are level sampled.
// Ports: clk; Clear sync reset; Power level enable; Ballot/Close/Result buttons; Total show-total
//        level; IN keypad. out display value, res_idx result index, armed, vote_ok/spoiled/timeout
//        pulses, ovf sticky saturation flag, leader.
// Optional: define VOTE_LEADER_EN to build the leading-candidate comparator; otherwise leader = 0.
module vote_tally
    import vote_pkg::*;
#(
    parameter int  N_CAND    = 4,
    parameter int  CNT_W     = 12,
    parameter int  BALLOT_TO = 16,
    localparam int IDX_W     = idx_w(N_CAND),
    localparam int LEAD_W    = lead_w(N_CAND)
) (
    input  logic              clk,
    input  logic              Clear,
    input  logic              Power,
    input  logic              Ballot,
    input  logic              Close,
    input  logic              Total,
    input  logic              Result,
    input  logic [N_CAND-1:0] IN,
    output logic [CNT_W-1:0]  out,
    output logic [IDX_W-1:0]  res_idx,
    output logic              armed,
    output logic              vote_ok,
    output logic              spoiled,
    output logic              timeout,
    output logic              ovf,
    output logic [LEAD_W-1:0] leader
);

    localparam int               TMR_W    = $clog2(BALLOT_TO);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BALLOT_TO - 1);
    localparam logic [IDX_W-1:0] IDX_SPL  = IDX_W'(N_CAND);

    logic w_ballot_e, w_close_e, w_result_e;

    vote_edge_det u_ballot (.i_clk(clk), .i_rst(Clear), .i_d(Ballot), .o_rise(w_ballot_e));
    vote_edge_det u_close  (.i_clk(clk), .i_rst(Clear), .i_d(Close),  .o_rise(w_close_e));
    vote_edge_det u_result (.i_clk(clk), .i_rst(Clear), .i_d(Result), .o_rise(w_result_e));

    state_t             r_state, w_state_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic [IDX_W-1:0]   r_res_idx, w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt [N_CAND];
    logic [CNT_W-1:0]   w_cnt_nxt [N_CAND];
    logic [CNT_W-1:0]   r_spl, w_spl_nxt;
    logic [CNT_W-1:0]   r_tot, w_tot_nxt;
    logic [CNT_W-1:0]   r_out, w_out_nxt, w_sel_cnt;
    logic               r_ovf, w_ovf_nxt;
    logic               r_vote_ok, r_spoiled, r_timeout;
    logic               w_vote_ok_nxt, w_spoiled_nxt, w_timeout_nxt;
    logic [15:0]        w_in16;
    logic               w_onehot;

    always_comb begin
        w_in16             = '0;
        w_in16[N_CAND-1:0] = IN;
    end

    assign w_onehot = is_onehot(w_in16);

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_idx_nxt     = r_res_idx;
        w_cnt_nxt     = r_cnt;
        w_spl_nxt     = r_spl;
        w_tot_nxt     = r_tot;
        w_ovf_nxt     = r_ovf;
        w_vote_ok_nxt = 1'b0;
        w_spoiled_nxt = 1'b0;
        w_timeout_nxt = 1'b0;

        if (!Power) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF: w_state_nxt = ST_IDLE;

                ST_IDLE: begin
                    if (w_close_e) begin
                        w_state_nxt = ST_CLOSED;
                        w_idx_nxt   = '0;
                    end else if (w_ballot_e) begin
                        w_state_nxt = ST_ARMED;
                        w_timer_nxt = '0;
                    end
                end

                ST_ARMED: begin
                    if (w_close_e) begin
                        // Closing the poll voids the ballot in hand, even if a key is down.
                        w_state_nxt = ST_CLOSED;
                        w_idx_nxt   = '0;
                    end else if (IN != '0) begin
                        w_state_nxt = ST_HOLD;
                        if (&r_tot) w_ovf_nxt = 1'b1;
                        else        w_tot_nxt = r_tot + CNT_W'(1);
                        if (w_onehot) begin
                            w_vote_ok_nxt = 1'b1;
                            for (int i = 0; i < N_CAND; i++) begin
                                if (IN[i]) begin
                                    if (&r_cnt[i]) w_ovf_nxt    = 1'b1;
                                    else           w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                                end
                            end
                        end else begin
                            w_spoiled_nxt = 1'b1;
                            if (&r_spl) w_ovf_nxt = 1'b1;
                            else        w_spl_nxt = r_spl + CNT_W'(1);
                        end
                    end else if (r_timer == TMR_LAST) begin
                        w_state_nxt   = ST_IDLE;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TMR_W'(1);
                    end
                end

                // One ballot, one count: stay here until every key is released.
                ST_HOLD: if (IN == '0) w_state_nxt = ST_IDLE;

                ST_CLOSED: begin
                    if (w_result_e) begin
                        w_idx_nxt = (r_res_idx == IDX_SPL) ? '0 : r_res_idx + IDX_W'(1);
                    end
                end

                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Display is built from next-state values so it moves in the same cycle as the counters.
    always_comb begin
        w_sel_cnt = w_spl_nxt;
        for (int i = 0; i < N_CAND; i++) begin
            if (w_idx_nxt == IDX_W'(i)) w_sel_cnt = w_cnt_nxt[i];
        end
        w_out_nxt = '0;
        if (w_state_nxt == ST_CLOSED) begin
            w_out_nxt = w_sel_cnt;
        end else if ((w_state_nxt == ST_IDLE) && Total) begin
            w_out_nxt = w_tot_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (Clear) begin
            r_state   <= Power ? ST_IDLE : ST_OFF;
            r_timer   <= '0;
            r_res_idx <= '0;
            for (int i = 0; i < N_CAND; i++) r_cnt[i] <= '0;
            r_spl     <= '0;
            r_tot     <= '0;
            r_out     <= '0;
            r_ovf     <= 1'b0;
            r_vote_ok <= 1'b0;
            r_spoiled <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_res_idx <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_spl     <= w_spl_nxt;
            r_tot     <= w_tot_nxt;
            r_out     <= w_out_nxt;
            r_ovf     <= w_ovf_nxt;
            r_vote_ok <= w_vote_ok_nxt;
            r_spoiled <= w_spoiled_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign out     = r_out;
    assign res_idx = r_res_idx;
    assign armed   = (r_state == ST_ARMED);
    assign vote_ok = r_vote_ok;
    assign spoiled = r_spoiled;
    assign timeout = r_timeout;
    assign ovf     = r_ovf;

`ifdef VOTE_LEADER_EN
    logic [LEAD_W-1:0] r_leader, w_best;
    logic [CNT_W-1:0]  w_best_cnt;

    // Strictly-greater scan from index 0 keeps the lowest index on ties.
    always_comb begin
        w_best     = '0;
        w_best_cnt = w_cnt_nxt[0];
        for (int i = 1; i < N_CAND; i++) begin
            if (w_cnt_nxt[i] > w_best_cnt) begin
                w_best     = LEAD_W'(i);
                w_best_cnt = w_cnt_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Clear) begin
            r_leader <= '0;
        end else begin
            r_leader <= (w_state_nxt == ST_CLOSED) ? w_best : '0;
        end
    end

    assign leader = r_leader;
`else
    assign leader = '0;
`endif

endmodule

// File: tb/tb_vote_tally.sv
// Purpose: self-checking bench for vote_tally with a cycle-level reference model.
// Latency: model advances on each rising edge; outputs compared on each falling edge.
// Backpressure: none.
module tb_vote_tally;

    localparam int N_CAND    = 4;
    localparam int CNT_W     = 12;
    localparam int BALLOT_TO = 16;
    localparam int IDX_W     = $clog2(N_CAND + 1);
    localparam int LEAD_W    = $clog2(N_CAND);
    localparam int MAXC      = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              Clear, Power, Ballot, Close, Total, Result;
    logic [N_CAND-1:0] IN;
    logic [CNT_W-1:0]  out;
    logic [IDX_W-1:0]  res_idx;
    logic              armed, vote_ok, spoiled, timeout, ovf;
    logic [LEAD_W-1:0] leader;

    always #5 clk = ~clk;

    vote_tally #(.N_CAND(N_CAND), .CNT_W(CNT_W), .BALLOT_TO(BALLOT_TO)) dut (
        .clk(clk), .Clear(Clear), .Power(Power), .Ballot(Ballot), .Close(Close),
        .Total(Total), .Result(Result), .IN(IN), .out(out), .res_idx(res_idx),
        .armed(armed), .vote_ok(vote_ok), .spoiled(spoiled), .timeout(timeout),
        .ovf(ovf), .leader(leader)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_OFF, M_IDLE, M_ARMED, M_HOLD, M_CLOSED} mode_t;
    mode_t m_mode = M_OFF;
    int    m_cnt [N_CAND];
    int    m_spl = 0, m_tot = 0, m_idx = 0, m_age = 0;
    bit    m_ovf = 0, m_vok = 0, m_spo = 0, m_tmo = 0, m_show = 0, m_valid = 0;
    bit    p_b = 0, p_c = 0, p_r = 0;

    always @(posedge clk) begin
        bit be, ce, re;
        int k;
        be = Ballot && !p_b;
        ce = Close  && !p_c;
        re = Result && !p_r;
        m_vok = 0; m_spo = 0; m_tmo = 0;
        if (Clear) begin
            m_valid = 1;
            m_mode  = Power ? M_IDLE : M_OFF;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_spl = 0; m_tot = 0; m_idx = 0; m_age = 0; m_ovf = 0; m_show = 0;
            p_b = 0; p_c = 0; p_r = 0;
        end else begin
            p_b = Ballot; p_c = Close; p_r = Result;
            m_show = Total;
            if (!Power) begin
                m_mode = M_OFF;
            end else begin
                case (m_mode)
                    M_OFF: m_mode = M_IDLE;
                    M_IDLE: begin
                        if (ce)      begin m_mode = M_CLOSED; m_idx = 0; end
                        else if (be) begin m_mode = M_ARMED;  m_age = 0; end
                    end
                    M_ARMED: begin
                        if (ce) begin
                            m_mode = M_CLOSED; m_idx = 0;
                        end else if (IN != 0) begin
                            m_mode = M_HOLD;
                            if (m_tot == MAXC) m_ovf = 1; else m_tot++;
                            if ($countones(IN) == 1) begin
                                m_vok = 1;
                                k = 0;
                                for (int i = 0; i < N_CAND; i++) if (IN[i]) k = i;
                                if (m_cnt[k] == MAXC) m_ovf = 1; else m_cnt[k]++;
                            end else begin
                                m_spo = 1;
                                if (m_spl == MAXC) m_ovf = 1; else m_spl++;
                            end
                        end else if (m_age == BALLOT_TO - 1) begin
                            m_mode = M_IDLE; m_tmo = 1;
                        end else begin
                            m_age++;
                        end
                    end
                    M_HOLD:   if (IN == 0) m_mode = M_IDLE;
                    M_CLOSED: if (re) m_idx = (m_idx + 1) % (N_CAND + 1);
                    default:  m_mode = M_IDLE;
                endcase
            end
        end
    end

    function automatic int exp_out();
        if (m_mode == M_CLOSED) return (m_idx == N_CAND) ? m_spl : m_cnt[m_idx];
        if (m_mode == M_IDLE && m_show) return m_tot;
        return 0;
    endfunction

    function automatic int exp_leader();
        int best;
        best = 0;
`ifdef VOTE_LEADER_EN
        if (m_mode != M_CLOSED) return 0;
        for (int i = 1; i < N_CAND; i++) if (m_cnt[i] > m_cnt[best]) best = i;
`endif
        return best;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("out",     int'(out),     exp_out());
            chk("res_idx", int'(res_idx), m_idx);
            chk("armed",   int'(armed),   int'(m_mode == M_ARMED));
            chk("vote_ok", int'(vote_ok), int'(m_vok));
            chk("spoiled", int'(spoiled), int'(m_spo));
            chk("timeout", int'(timeout), int'(m_tmo));
            chk("ovf",     int'(ovf),     int'(m_ovf));
            chk("leader",  int'(leader),  exp_leader());
        end
    end

    // Pulse tallies taken from the DUT for the hand-computed checks.
    int n_vok = 0, n_spo = 0, n_tmo = 0;
    always @(posedge clk) begin
        n_vok += int'(vote_ok);
        n_spo += int'(spoiled);
        n_tmo += int'(timeout);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_clear();
        Clear = 1'b1; tick();
        Clear = 1'b0;
    endtask

    task automatic vote(input logic [N_CAND-1:0] keys);
        Ballot = 1'b1; IN = '0;   tick();
        Ballot = 1'b0; IN = keys; tick();
        IN = '0; tick();
    endtask

    task automatic do_close();
        Close = 1'b1; tick();
        Close = 1'b0;
    endtask

    task automatic step();
        Result = 1'b1; tick();
        Result = 1'b0; tick();
    endtask

    task automatic show_total(input int exp, input string nm);
        Total = 1'b1; tick();
        chk(nm, int'(out), exp);
        Total = 1'b0;
    endtask

    initial begin
        int base_v, base_s, base_t;
        int s1_out [5];
        int r;
        Clear = 1'b0; Power = 1'b1; Ballot = 1'b0; Close = 1'b0;
        Total = 1'b0; Result = 1'b0; IN = '0;
        tick();

        // Reset state
        Clear = 1'b1; Total = 1'b1; tick();
        chk("reset_out", int'(out), 0);
        chk("reset_armed", int'(armed), 0);
        chk("reset_ovf", int'(ovf), 0);
        Clear = 1'b0; Total = 1'b0;

        // Valid votes: 3 for candidate 0, 2 for candidate 2
        base_v = n_vok;
        repeat (3) vote(4'b0001);
        repeat (2) vote(4'b0100);
        chk("s1_vote_ok_pulses", n_vok - base_v, 5);
        show_total(5, "s1_total");
        do_close();
        chk("s1_idx0", int'(res_idx), 0);
        chk("s1_out0", int'(out), 3);
        s1_out = '{0, 2, 0, 0, 3};
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s1_idx_step", int'(res_idx), (i + 1) % 5);
            chk("s1_out_step", int'(out), s1_out[i]);
        end

        // Spoiled ballots
        do_clear();
        base_s = n_spo;
        vote(4'b0101);
        vote(4'b1111);
        chk("s2_spoiled_pulses", n_spo - base_s, 2);
        show_total(2, "s2_total");
        do_close();
        chk("s2_cnt0", int'(out), 0);
        repeat (4) step();
        chk("s2_idx_spl", int'(res_idx), 4);
        chk("s2_spl", int'(out), 2);

        // Held key, changed while held, counts once
        do_clear();
        Ballot = 1'b1; tick();
        Ballot = 1'b0; IN = 4'b0001;
        repeat (20) tick();
        IN = 4'b0010;
        repeat (3) tick();
        IN = '0; tick();
        do_close();
        chk("s3_cnt0", int'(out), 1);
        step();
        chk("s3_cnt1", int'(out), 0);

        // Ballot timeout, then key without a ballot
        do_clear();
        base_t = n_tmo;
        Ballot = 1'b1; tick();
        Ballot = 1'b0;
        repeat (15) tick();
        chk("s4_still_armed", int'(armed), 1);
        repeat (2) tick();
        chk("s4_timeout_pulses", n_tmo - base_t, 1);
        chk("s4_disarmed", int'(armed), 0);
        IN = 4'b0001; repeat (3) tick();
        IN = '0;
        show_total(0, "s4_no_count");

        // Saturation at full scale
        do_clear();
        repeat (MAXC) vote(4'b1000);
        chk("s6_ovf_at_max", int'(ovf), 0);
        show_total(MAXC, "s6_total_max");
        vote(4'b1000);
        vote(4'b1000);
        chk("s6_ovf_set", int'(ovf), 1);
        show_total(MAXC, "s6_total_sat");
        do_close();
        repeat (3) step();
        chk("s6_idx3", int'(res_idx), 3);
        chk("s6_cnt3_sat", int'(out), MAXC);

        // Clear while a ballot is armed
        do_clear();
        chk("s7_ovf_cleared", int'(ovf), 0);
        Ballot = 1'b1; tick();
        Ballot = 1'b0; tick();
        chk("s7_armed", int'(armed), 1);
        Clear = 1'b1; IN = 4'b0001; tick();
        Clear = 1'b0; IN = '0;
        chk("s7_armed_after_clear", int'(armed), 0);
        show_total(0, "s7_total_zero");

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            Clear  = ($urandom_range(0, 299) == 0);
            Power  = ($urandom_range(0, 119) != 0);
            Ballot = ($urandom_range(0, 3) == 0);
            Close  = ($urandom_range(0, 49) == 0);
            Result = ($urandom_range(0, 2) == 0);
            Total  = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 19);
            if (r < 10)      IN = '0;
            else if (r < 17) IN = 4'b0001 << $urandom_range(0, 3);
            else             IN = 4'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
